// File: rtl/execute_flag_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module : execute_flag_cond_pkg
// Brief  : Shared execute-stage definitions: condition-code encodings,
//          flag bit positions and flag vector width.
// Rev    : 1.0  initial release
// ============================================================================
package execute_flag_cond_pkg;

   localparam int FLAG_W = 5;
   localparam int CC_W   = 4;

   // Bit positions inside the {SF,OF,CF,PF,ZF} flag vector
   localparam int FLAG_SF = 4;
   localparam int FLAG_OF = 3;
   localparam int FLAG_CF = 2;
   localparam int FLAG_PF = 1;
   localparam int FLAG_ZF = 0;

   typedef logic [FLAG_W-1:0] flags_t;

   typedef enum logic [CC_W-1:0] {
      CC_AL = 4'h0,
      CC_EQ = 4'h1,
      CC_NE = 4'h2,
      CC_MI = 4'h3,
      CC_PL = 4'h4,
      CC_PS = 4'h5,
      CC_PC = 4'h6,
      CC_OV = 4'h7,
      CC_NO = 4'h8,
      CC_CS = 4'h9,
      CC_CC = 4'hA,
      CC_GT = 4'hB,
      CC_GE = 4'hC,
      CC_LT = 4'hD,
      CC_LE = 4'hE,
      CC_NV = 4'hF
   } cc_e;

endpackage
`default_nettype wire

// File: rtl/execute_flag_cond_if.sv
`default_nettype none
// ============================================================================
// Module : execute_flag_cond_if
// Brief  : Stage bundle between the execute units, the flag/condition stage
//          and writeback. The slave side is the stage itself.
// Rev    : 1.0  initial release
// ============================================================================
interface execute_flag_cond_if
   import execute_flag_cond_pkg::*;
#(
   parameter int P_N = 32
);
   logic             iEVENT_FLUSH;
   logic             iRESTORE_VALID;
   flags_t           iRESTORE_FLAGS;
   logic             iPREVIOUS_VALID;
   logic             oPREVIOUS_LOCK;
   logic [P_N-1:0]   iPREVIOUS_DATA;
   logic             iPREVIOUS_FLAGS_WRITE;
   flags_t           iPREVIOUS_FLAGS;
   logic             iPREVIOUS_CC_CHECK;
   logic [CC_W-1:0]  iPREVIOUS_CC;
   logic             oNEXT_VALID;
   logic             iNEXT_LOCK;
   logic [P_N-1:0]   oNEXT_DATA;
   logic             oNEXT_CC_TRUE;
   flags_t           oFLAGS;

   modport slave (
      input  iEVENT_FLUSH, iRESTORE_VALID, iRESTORE_FLAGS,
      input  iPREVIOUS_VALID, iPREVIOUS_DATA, iPREVIOUS_FLAGS_WRITE,
      input  iPREVIOUS_FLAGS, iPREVIOUS_CC_CHECK, iPREVIOUS_CC, iNEXT_LOCK,
      output oPREVIOUS_LOCK, oNEXT_VALID, oNEXT_DATA, oNEXT_CC_TRUE, oFLAGS
   );

   modport master (
      output iEVENT_FLUSH, iRESTORE_VALID, iRESTORE_FLAGS,
      output iPREVIOUS_VALID, iPREVIOUS_DATA, iPREVIOUS_FLAGS_WRITE,
      output iPREVIOUS_FLAGS, iPREVIOUS_CC_CHECK, iPREVIOUS_CC, iNEXT_LOCK,
      input  oPREVIOUS_LOCK, oNEXT_VALID, oNEXT_DATA, oNEXT_CC_TRUE, oFLAGS
   );

endinterface
`default_nettype wire

// File: rtl/execute_flag_cond_eval.sv
`default_nettype none
// ============================================================================
// Module : execute_flag_cond_eval
// Brief  : Combinational condition-code evaluator against a flag vector.
//          Kept standalone so the branch unit can reuse it.
// Rev    : 1.0  initial release
// ============================================================================
module execute_flag_cond_eval
   import execute_flag_cond_pkg::*;
(
   input  wire logic [CC_W-1:0] cc,
   input  wire flags_t          flags,
   output logic                 true
);

   logic w_s, w_o, w_c, w_p, w_z;

   assign w_s = flags[FLAG_SF];
   assign w_o = flags[FLAG_OF];
   assign w_c = flags[FLAG_CF];
   assign w_p = flags[FLAG_PF];
   assign w_z = flags[FLAG_ZF];

   // Decode the condition code into a single pass/fail bit
   always_comb begin
      true = 1'b0;
      case (cc)
         CC_AL: true = 1'b1;
         CC_EQ: true = w_z;
         CC_NE: true = !w_z;
         CC_MI: true = w_s;
         CC_PL: true = !w_s;
         CC_PS: true = w_p;
         CC_PC: true = !w_p;
         CC_OV: true = w_o;
         CC_NO: true = !w_o;
         CC_CS: true = w_c;
         CC_CC: true = !w_c;
         CC_GT: true = !w_z && (w_s == w_o);
         CC_GE: true = (w_s == w_o);
         CC_LT: true = (w_s != w_o);
         CC_LE: true = w_z || (w_s != w_o);
         CC_NV: true = 1'b0;
         default: true = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/execute_flag_cond.sv
`default_nettype none
// ============================================================================
// Module : execute_flag_cond
// Brief  : Execute-to-writeback pipeline stage that owns the architectural
//          flags. Evaluates condition codes against forwarded flags,
//          predicates flag writes and commits flags when an instruction
//          leaves the stage.
// Rev    : 1.0  initial release
// ============================================================================
module execute_flag_cond
   import execute_flag_cond_pkg::*;
#(
   parameter int P_N = 32
)(
   input  wire logic          iCLOCK,
   input  wire logic          inRESET,
   execute_flag_cond_if.slave bus
);

   logic             r_valid;
   logic [P_N-1:0]   r_data;
   logic             r_cc_true;
   flags_t           r_pend_flags;
   logic             r_pend_wr;
   flags_t           r_flags;

   logic             w_lock;
   logic             w_accept;
   logic             w_transfer;
   flags_t           w_eff_flags;
   logic             w_cond;
   logic             w_cc_true;

   assign w_lock     = r_valid && bus.iNEXT_LOCK;
   assign w_accept   = bus.iPREVIOUS_VALID && !w_lock && !bus.iEVENT_FLUSH;
   assign w_transfer = r_valid && !bus.iNEXT_LOCK;

   // A flag write still sitting in the stage is forwarded so a dependent
   // conditional instruction right behind it needs no bubble.
   assign w_eff_flags = (r_valid && r_pend_wr) ? r_pend_flags : r_flags;

   execute_flag_cond_eval u_eval (
      .cc    (bus.iPREVIOUS_CC),
      .flags (w_eff_flags),
      .true  (w_cond)
   );

   assign w_cc_true = !bus.iPREVIOUS_CC_CHECK || w_cond;

   // Stage register: flush drops contents, accept loads, lone transfer empties
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         r_valid      <= 1'b0;
         r_data       <= '0;
         r_cc_true    <= 1'b0;
         r_pend_flags <= '0;
         r_pend_wr    <= 1'b0;
      end else if (bus.iEVENT_FLUSH) begin
         r_valid   <= 1'b0;
         r_pend_wr <= 1'b0;
      end else if (w_accept) begin
         r_valid      <= 1'b1;
         r_data       <= bus.iPREVIOUS_DATA;
         r_cc_true    <= w_cc_true;
         r_pend_flags <= bus.iPREVIOUS_FLAGS;
         r_pend_wr    <= bus.iPREVIOUS_FLAGS_WRITE && w_cc_true;
      end else if (w_transfer) begin
         r_valid   <= 1'b0;
         r_pend_wr <= 1'b0;
      end
   end

   // Architectural flags: restore wins, flush suppresses the pending commit
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         r_flags <= '0;
      end else if (bus.iRESTORE_VALID) begin
         r_flags <= bus.iRESTORE_FLAGS;
      end else if (!bus.iEVENT_FLUSH && w_transfer && r_pend_wr) begin
         r_flags <= r_pend_flags;
      end
   end

   assign bus.oPREVIOUS_LOCK = w_lock;
   assign bus.oNEXT_VALID    = r_valid;
   assign bus.oNEXT_DATA     = r_data;
   assign bus.oNEXT_CC_TRUE  = r_cc_true;
   assign bus.oFLAGS         = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_execute_flag_cond.sv
`default_nettype none
// ============================================================================
// Module : tb_execute_flag_cond
// Brief  : Self-checking bench for execute_flag_cond: vector table, a
//          condition-code sweep and an asynchronous reset sequence, with a
//          scoreboard for instructions leaving the stage.
// Rev    : 1.0  initial release
// ============================================================================
module tb_execute_flag_cond;
   import execute_flag_cond_pkg::*;

   typedef struct {
      logic        flush;
      logic        rv;
      logic [4:0]  rf;
      logic        pv;
      logic [31:0] data;
      logic        fw;
      logic [4:0]  fl;
      logic        ccc;
      logic [3:0]  cc;
      logic        nl;
      logic        e_lock;
      logic        e_acc;
      logic        e_valid;
      logic        e_cc;
      logic [4:0]  e_flags;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic        cc;
   } sb_t;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;
   vec_t tv[$];
   sb_t  sbq[$];

   execute_flag_cond_if #(.P_N(32)) bus ();

   execute_flag_cond #(.P_N(32)) dut (
      .iCLOCK  (clk),
      .inRESET (rst_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t v(input logic flush, input logic rv, input logic [4:0] rf,
                              input logic pv, input logic [31:0] data, input logic fw,
                              input logic [4:0] fl, input logic ccc, input logic [3:0] cc,
                              input logic nl, input logic e_lock, input logic e_acc,
                              input logic e_valid, input logic e_cc, input logic [4:0] e_flags);
      vec_t r;
      r.flush = flush; r.rv = rv; r.rf = rf; r.pv = pv; r.data = data; r.fw = fw;
      r.fl = fl; r.ccc = ccc; r.cc = cc; r.nl = nl; r.e_lock = e_lock; r.e_acc = e_acc;
      r.e_valid = e_valid; r.e_cc = e_cc; r.e_flags = e_flags;
      return r;
   endfunction

   function automatic logic cc_ref(input logic [3:0] c, input logic [4:0] f);
      logic s, o, cy, p, z;
      s = f[4]; o = f[3]; cy = f[2]; p = f[1]; z = f[0];
      case (c)
         4'h0: return 1'b1;
         4'h1: return z;
         4'h2: return ~z;
         4'h3: return s;
         4'h4: return ~s;
         4'h5: return p;
         4'h6: return ~p;
         4'h7: return o;
         4'h8: return ~o;
         4'h9: return cy;
         4'hA: return ~cy;
         4'hB: return ~z & ~(s ^ o);
         4'hC: return ~(s ^ o);
         4'hD: return s ^ o;
         4'hE: return z | (s ^ o);
         default: return 1'b0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called with clk low; leaves with clk low after the next negedge
   task automatic apply(input vec_t x);
      sb_t s;
      bus.iEVENT_FLUSH          = x.flush;
      bus.iRESTORE_VALID        = x.rv;
      bus.iRESTORE_FLAGS        = x.rf;
      bus.iPREVIOUS_VALID       = x.pv;
      bus.iPREVIOUS_DATA        = x.data;
      bus.iPREVIOUS_FLAGS_WRITE = x.fw;
      bus.iPREVIOUS_FLAGS       = x.fl;
      bus.iPREVIOUS_CC_CHECK    = x.ccc;
      bus.iPREVIOUS_CC          = x.cc;
      bus.iNEXT_LOCK            = x.nl;
      #1;
      chk("prev_lock", {31'd0, bus.oPREVIOUS_LOCK}, {31'd0, x.e_lock});
      if (bus.oNEXT_VALID && x.flush) begin
         if (sbq.size() > 0) void'(sbq.pop_front());
      end else if (bus.oNEXT_VALID && !x.nl) begin
         if (sbq.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            s = sbq.pop_front();
            chk("sb_data", bus.oNEXT_DATA, s.data);
            chk("sb_cc_true", {31'd0, bus.oNEXT_CC_TRUE}, {31'd0, s.cc});
         end
      end
      if (x.e_acc) begin
         s.data = x.data;
         s.cc   = x.e_cc;
         sbq.push_back(s);
      end
      @(posedge clk);
      #1;
      chk("next_valid", {31'd0, bus.oNEXT_VALID}, {31'd0, x.e_valid});
      chk("flags", {27'd0, bus.oFLAGS}, {27'd0, x.e_flags});
      if (x.e_valid) chk("next_cc_true", {31'd0, bus.oNEXT_CC_TRUE}, {31'd0, x.e_cc});
      @(negedge clk);
   endtask

   initial begin
      logic [4:0] pats [6];
      n_chk  = 0;
      n_fail = 0;
      pats[0] = 5'b00000; pats[1] = 5'b11111; pats[2] = 5'b10101;
      pats[3] = 5'b01010; pats[4] = 5'b10001; pats[5] = 5'b01000;

      rst_n = 1'b0;
      apply(v(0,0,0, 0,0,0,0,0,CC_AL,0, 0,0,0,0,5'b00000));
      chk("rst_data", bus.oNEXT_DATA, 32'd0);
      chk("rst_cc_true", {31'd0, bus.oNEXT_CC_TRUE}, 32'd0);
      rst_n = 1'b1;

      // single write, forwarding EQ/NE, predication, backpressure, flush, restore
      tv.push_back(v(0,0,0,         1,32'hA1,1,5'b00001,0,CC_AL,0, 0,1,1,1,5'b00000));
      tv.push_back(v(0,0,0,         1,32'hA2,0,5'b00000,1,CC_EQ,0, 0,1,1,1,5'b00001));
      tv.push_back(v(0,0,0,         1,32'hA3,1,5'b00000,0,CC_AL,0, 0,1,1,1,5'b00001));
      tv.push_back(v(0,0,0,         1,32'hA4,0,5'b00000,1,CC_NE,0, 0,1,1,1,5'b00000));
      tv.push_back(v(0,0,0,         1,32'hA5,1,5'b00001,0,CC_AL,0, 0,1,1,1,5'b00000));
      tv.push_back(v(0,0,0,         1,32'hA6,1,5'b10000,1,CC_NE,0, 0,1,1,0,5'b00001));
      tv.push_back(v(0,0,0,         0,32'h00,0,5'b00000,0,CC_AL,0, 0,0,0,0,5'b00001));
      tv.push_back(v(0,0,0,         1,32'hA8,1,5'b01000,0,CC_AL,0, 0,1,1,1,5'b00001));
      tv.push_back(v(0,0,0,         1,32'hA9,0,5'b00000,0,CC_AL,1, 1,0,1,1,5'b00001));
      tv.push_back(v(0,0,0,         1,32'hA9,0,5'b00000,0,CC_AL,1, 1,0,1,1,5'b00001));
      tv.push_back(v(0,0,0,         1,32'hA9,0,5'b00000,0,CC_AL,1, 1,0,1,1,5'b00001));
      tv.push_back(v(0,0,0,         1,32'hA9,0,5'b00000,0,CC_AL,0, 0,1,1,1,5'b01000));
      tv.push_back(v(0,0,0,         1,32'hAD,1,5'b00100,0,CC_AL,0, 0,1,1,1,5'b01000));
      tv.push_back(v(1,0,0,         1,32'hAE,1,5'b11111,0,CC_AL,0, 0,0,0,0,5'b01000));
      tv.push_back(v(0,0,0,         0,32'h00,0,5'b00000,0,CC_AL,0, 0,0,0,0,5'b01000));
      tv.push_back(v(0,0,0,         1,32'hB0,1,5'b00001,0,CC_AL,0, 0,1,1,1,5'b01000));
      tv.push_back(v(0,1,5'b11111,  0,32'h00,0,5'b00000,0,CC_AL,0, 0,0,0,0,5'b11111));
      tv.push_back(v(0,0,0,         1,32'hB2,1,5'b00010,0,CC_AL,0, 0,1,1,1,5'b11111));
      tv.push_back(v(1,1,5'b00110,  0,32'h00,0,5'b00000,0,CC_AL,0, 0,0,0,0,5'b00110));
      tv.push_back(v(0,0,0,         1,32'hB4,1,5'b10000,1,CC_GT,0, 0,1,1,1,5'b00110));
      tv.push_back(v(0,0,0,         1,32'hB5,0,5'b00000,1,CC_LT,0, 0,1,1,1,5'b10000));
      tv.push_back(v(0,0,0,         1,32'hB6,1,5'b00011,1,CC_NV,0, 0,1,1,0,5'b10000));
      tv.push_back(v(0,0,0,         1,32'hB7,1,5'b00011,1,CC_AL,0, 0,1,1,1,5'b10000));
      tv.push_back(v(0,0,0,         0,32'h00,0,5'b00000,0,CC_AL,0, 0,0,0,0,5'b00011));
      for (int i = 0; i < tv.size(); i++) apply(tv[i]);

      // condition-code sweep against restored architectural flags
      for (int p = 0; p < 6; p++) begin
         apply(v(0,1,pats[p], 0,32'h0,0,5'b00000,0,CC_AL,0, 0,0,0,0,pats[p]));
         for (int c = 0; c < 16; c++) begin
            apply(v(0,0,0, 1,32'hC000_0000 | (p*16+c),0,5'b00000,1,4'(c),0,
                    0,1,1,cc_ref(4'(c), pats[p]),pats[p]));
         end
         apply(v(0,0,0, 0,32'h0,0,5'b00000,0,CC_AL,0, 0,0,0,0,pats[p]));
      end
      chk("sb_empty", sbq.size(), 32'd0);

      // asynchronous reset in the middle of a stall
      apply(v(0,1,5'b10101, 1,32'hDEADBEEF,1,5'b11111,0,CC_AL,0, 0,1,1,1,5'b10101));
      apply(v(0,0,0,        1,32'h00000001,0,5'b00000,0,CC_AL,1, 1,0,1,1,5'b10101));
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, bus.oNEXT_VALID}, 32'd0);
      chk("arst_data", bus.oNEXT_DATA, 32'd0);
      chk("arst_cc_true", {31'd0, bus.oNEXT_CC_TRUE}, 32'd0);
      chk("arst_flags", {27'd0, bus.oFLAGS}, 32'd0);
      chk("arst_lock", {31'd0, bus.oPREVIOUS_LOCK}, 32'd0);
      sbq.delete();
      @(negedge clk);
      rst_n = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
